// File: rtl/seq_mul_issue_ctrl.sv
// seq_mul_issue_ctrl: queues signed operand pairs, runs them one at a time through
// sequential_multiplier, returns each product on a valid/ready port and flags hung multiplies.
module seq_mul_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 20
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         mul_multiplier,
  output logic [WIDTH-1:0]         mul_multiplicand,
  output logic                     mul_start,
  input  logic [2*WIDTH-1:0]       mul_product,
  input  logic                     mul_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_product,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, GUARD, WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [TW-1:0] to_q, to_d;
  logic guard_q, guard_d, err_q, err_d;
  logic push, pop;
  assign in_ready         = n_rst && cnt_q < CW'(DEPTH);
  assign push             = in_valid && in_ready;
  assign pop              = state_q == IDLE && cnt_q != '0;
  assign mul_start        = state_q == START;
  assign out_valid        = state_q == OUT;
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign out_product      = prod_q;
  assign fifo_count       = cnt_q;
  assign err              = err_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {in_a, in_b};
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    guard_d = state_q == GUARD && !guard_q;
    to_d    = state_q == WAIT ? to_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (pop) begin
        a_d     = mem_q[rd_q][2*WIDTH-1:WIDTH];
        b_d     = mem_q[rd_q][WIDTH-1:0];
        state_d = START;
      end
      START: state_d = GUARD;
      // mul_ready may still be stale from the previous operation for two cycles
      GUARD: state_d = guard_q ? WAIT : GUARD;
      WAIT: if (mul_ready) begin
        prod_d  = mul_product;
        state_d = OUT;
      end else if (to_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      to_q    <= '0;
      guard_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      to_q    <= to_d;
      guard_q <= guard_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_seq_mul_issue_ctrl.sv
// tb_seq_mul_issue_ctrl: directed stimulus with a product scoreboard, plus a
// behavioural sequential_multiplier whose ready lingers one cycle after start.
module tb_seq_mul_issue_ctrl;
  logic clk = 0, n_rst = 0;
  logic in_valid = 0, in_ready, out_ready = 1, mul_start, mul_ready, out_valid, err;
  logic [15:0] in_a = 0, in_b = 0, mul_multiplier, mul_multiplicand;
  logic [31:0] mul_product, out_product;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0, starts = 0, lat = 3;
  bit hang = 0;
  logic [31:0] exp_q[$];

  seq_mul_issue_ctrl dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_start(mul_start),
    .mul_product(mul_product), .mul_ready(mul_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  logic signed [15:0] m_a, m_b;
  logic signed [31:0] m_prod;
  int m_cnt;
  logic m_rdy;
  assign mul_product = m_prod;
  assign mul_ready = m_rdy;
  always @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      m_rdy <= 1; m_prod <= 0; m_cnt <= 0; m_a <= 0; m_b <= 0;
    end else if (mul_start) begin
      m_cnt <= lat + 1; m_a <= mul_multiplier; m_b <= mul_multiplicand;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      m_rdy <= (m_cnt == 1) && !hang;
      if (m_cnt == 1) m_prod <= m_a * m_b;
    end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  logic [31:0] prev_p;
  bit hold = 0, start_prev = 0;
  always begin
    @(negedge clk);
    #2;
    if (!n_rst) begin
      hold = 0; start_prev = 0;
    end else begin
      if (mul_start) starts++;
      if (mul_start && start_prev) chk("start_one_cycle", 1, 0);
      start_prev = mul_start;
      if (hold) chk("hold_stable", {out_valid, out_product}, {1'b1, prev_p});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", out_product, 64'hx);
        else chk("product", out_product, exp_q.pop_front());
      end
      hold = out_valid && !out_ready;
      prev_p = out_product;
    end
  end

  task automatic push(input int a, input int b, input int p, input bit want);
    int n = 0;
    in_a = 16'(a); in_b = 16'(b); in_valid = 1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    else begin
      if (want) exp_q.push_back(32'(p));
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0 || out_valid) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("drain_done", {exp_q.size() != 0, fifo_count != 0}, 0);
  endtask

  initial begin
    logic [7:0] sv, ov;
    logic [31:0] eh;
    int s0, n, ovc;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mplier", mul_multiplier, 0);
    chk("rst_mcand", mul_multiplicand, 0);
    chk("rst_product", out_product, 0);
    n_rst = 1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    push(10, -1, -10, 1);
    chk("single_count1", fifo_count, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      sv[i-1] = mul_start; ov[i-1] = out_valid;
      if (i == 1) chk("single_operands", {mul_multiplier, mul_multiplicand}, {16'd10, 16'hFFFF});
    end
    chk("single_start_timing", sv, 8'h01);
    chk("single_valid_timing", ov, 8'h40);
    chk("single_count0", fifo_count, 0);

    push(-32768, -32768, 1073741824, 1);
    push(0, -1, 0, 1);
    push(-1, 0, 0, 1);
    drain();

    out_ready = 0;
    push(-100, -1001, 100100, 1);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", out_valid, 1);
    s0 = starts;
    push(1, 1, 1, 1);
    push(2, -3, -6, 1);
    push(-7, 7, -49, 1);
    push(100, 200, 20000, 1);
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    repeat (46) @(negedge clk);
    chk("bp_no_start", starts - s0, 0);
    chk("bp_product", {out_valid, out_product}, {1'b1, 32'd100100});
    in_a = 16'(-5); in_b = 16'(-5); in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("hs_idle", {out_valid, mul_start, fifo_count, in_ready}, {1'b0, 1'b0, 3'd4, 1'b0});
    @(negedge clk);
    chk("restart_after_hs", {mul_start, fifo_count, in_ready}, {1'b1, 3'd3, 1'b1});
    exp_q.push_back(32'd25);
    @(negedge clk);
    in_valid = 0;
    chk("fifth_accepted", fifo_count, 4);
    drain();

    hang = 1;
    push(3, 4, 0, 0);
    push(6, 7, 42, 1);
    eh = 0; ovc = 0;
    for (int i = 2; i <= 25; i++) begin
      @(negedge clk);
      eh[i] = err;
      if (out_valid) ovc++;
      if (i == 10) hang = 0;
    end
    chk("timeout_err_timing", eh, 32'h0300_0000);
    chk("timeout_no_out", ovc, 0);
    drain();
    chk("err_sticky", err, 1);

    hang = 1;
    push(1, 2, 0, 0);
    push(3, 3, 0, 0);
    push(4, 4, 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_count", fifo_count, 2);
    #2 n_rst = 0;
    #1;
    chk("async_rst_outputs",
        {mul_start, out_valid, err, fifo_count, in_ready, mul_multiplier, mul_multiplicand, out_product},
        0);
    @(negedge clk);
    n_rst = 1; hang = 0;
    s0 = starts; ovc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    chk("post_rst_quiet", {ovc, starts - s0, 29'(fifo_count)}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
